// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : Wide add/subtract sequenced through one 4-bit adder slice,
//            LSB nibble first, with the carry chained between cycles.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);

    localparam logic [1:0]      C_IDLE = 2'd0;
    localparam logic [1:0]      C_ADD  = 2'd1;
    localparam logic [1:0]      C_DONE = 2'd2;
    localparam logic [IDXW-1:0] C_LAST = IDXW'(NIBBLES - 1);

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_q, b_q, part_q, result_q;
    logic            c_q, cout_q, ovf_q;
    logic [IDXW-1:0] idx_q;

    logic [3:0]      w_a_nib, w_b_nib, w_sum;
    logic [4:0]      w_sum5;
    logic [3:0]      w_low4;
    logic            w_c_next, w_c3, w_last, w_accept;
    logic [W-1:0]    w_part_next;

    // Shared 4-bit slice; the low three bits are summed separately so the
    // carry into the top bit is available for signed overflow.
    assign w_a_nib  = a_q[4*idx_q +: 4];
    assign w_b_nib  = b_q[4*idx_q +: 4];
    assign w_sum5   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, c_q};
    assign w_sum    = w_sum5[3:0];
    assign w_c_next = w_sum5[4];
    assign w_low4   = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b0, c_q};
    assign w_c3     = w_low4[3];
    assign w_last   = (idx_q == C_LAST);
    assign w_accept = start && (state_q != C_ADD);

    always_comb begin
        w_part_next                = part_q;
        w_part_next[4*idx_q +: 4]  = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  state_d = start ? C_ADD : C_IDLE;
            C_ADD:   state_d = w_last ? C_DONE : C_ADD;
            C_DONE:  state_d = start ? C_ADD : C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            C_ADD:   busy = 1'b1;
            C_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1, the +1 entering as the first carry.
            a_q    <= op_a;
            b_q    <= sub ? ~op_b : op_b;
            c_q    <= sub;
            idx_q  <= '0;
            part_q <= '0;
        end else if (state_q == C_ADD) begin
            part_q <= w_part_next;
            c_q    <= w_c_next;
            idx_q  <= idx_q + IDXW'(1);
            if (w_last) begin
                result_q <= w_part_next;
                cout_q   <= w_c_next;
                ovf_q    <= w_c3 ^ w_c_next;
            end
        end
    end

    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Directed vector bench for nibble_serial_adder_ctrl (NIBBLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, done, carry_out, overflow;
    logic [15:0] result;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1; on return the DUT is in its DONE cycle.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input bit hold, input logic [15:0] er, input logic ec,
                      input logic ev, input string nm);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk); #1;
        if (hold) begin
            op_a = 16'hAAAA; op_b = 16'h5555; sub = ~s;
        end else begin
            start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
        end
        for (int i = 0; i < 4; i++) begin
            check({nm, " busy/done in ADD"}, {30'b0, busy, done}, 32'b10);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({nm, " busy/done in DONE"}, {30'b0, busy, done}, 32'b01);
        check({nm, " result"}, {16'b0, result}, {16'b0, er});
        check({nm, " carry_out"}, {31'b0, carry_out}, {31'b0, ec});
        check({nm, " overflow"}, {31'b0, overflow}, {31'b0, ev});
    endtask

    task automatic idle_cycle(input string nm);
        @(posedge clk); #1;
        check({nm, " idle busy/done"}, {30'b0, busy, done}, 32'b00);
    endtask

    initial begin
        vecs[0] = '{16'h0001, 16'h000F, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", {16'b0, result}, 32'd0);
        check("reset carry_out", {31'b0, carry_out}, 32'd0);
        check("reset overflow", {31'b0, overflow}, 32'd0);
        rst_n = 1'b1;
        idle_cycle("post-reset");

        for (int i = 0; i < 10; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, vecs[i].res, vecs[i].c,
               vecs[i].v, $sformatf("vec%0d", i));
            idle_cycle($sformatf("vec%0d", i));
        end

        // start held through ADD is ignored; start in DONE chains with no IDLE.
        op(16'h0001, 16'h000F, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, "held-start");
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "chained");
        idle_cycle("chained");

        // Reset two ADD edges into an operation.
        start = 1'b1; op_a = 16'h00FF; op_b = 16'h0001; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset done", {31'b0, done}, 32'd0);
        check("async reset result", {16'b0, result}, 32'd0);
        check("async reset carry_out", {31'b0, carry_out}, 32'd0);
        check("async reset overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) idle_cycle("after reset");
        op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, "post-reset op");
        idle_cycle("post-reset op");

        // Result fields hold while inputs wander with start low.
        op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "hold op");
        for (int i = 0; i < 10; i++) begin
            op_a = 16'($urandom); op_b = 16'($urandom); sub = ~sub;
            @(posedge clk); #1;
            check("hold done", {31'b0, done}, 32'd0);
            check("hold result", {16'b0, result}, 32'h7FFF);
            check("hold carry_out", {31'b0, carry_out}, 32'd1);
            check("hold overflow", {31'b0, overflow}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
